hazard_scoreboard: RTL and testbench

- Parametrised successor to the fixed two-source hazards controller in the pipelined RISC-V core.
- Tracks in-flight register writes in a WB_DEPTH-entry shift scoreboard.
- Detects read-after-write hazards for NUM_SRC source operands, with optional bypass of the final stage.
- Generates the memory stall and a configurable-length control-hazard squash after taken jumps. Sits beside decode; its outputs gate fetch, decode squash and pipeline latches.

---
 rtl/hazard_scoreboard_if.sv | 38 +++
 rtl/hazard_scoreboard.sv | 104 ++++++++++
 tb/tb_hazard_scoreboard.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_if.sv
// Decode-side hazard bus between the decode stage and the hazard scoreboard.
//
// Handshake: issue_valid qualifies src_addr/src_valid/dst_addr/dst_wr as a real
// instruction in decode. dmem_ready/imem_ready are memory-side ready flags.
// A low ready raises stall in the same cycle, and all pipeline state holds on
// that edge. Nothing is accepted or advanced on an edge where stall is high.
interface hazard_scoreboard_if #(
    parameter int NUM_SRC    = 2,
    parameter int REG_ADDR_W = 5,
    parameter int WB_DEPTH   = 3
);
    logic [NUM_SRC*REG_ADDR_W-1:0] src_addr;
    logic [NUM_SRC-1:0]            src_valid;
    logic [REG_ADDR_W-1:0]         dst_addr;
    logic                          dst_wr;
    logic                          issue_valid;
    logic                          jump_taken;
    logic                          dmem_ready;
    logic                          imem_ready;
    logic                          stall;
    logic                          data_hazard;
    logic                          control_hazard;
    logic [WB_DEPTH-1:0]           sb_valid;

    // Pipeline side: drives decode/memory status and consumes hazard controls.
    modport master (
        output src_addr, src_valid, dst_addr, dst_wr, issue_valid,
        output jump_taken, dmem_ready, imem_ready,
        input  stall, data_hazard, control_hazard, sb_valid
    );

    // Scoreboard side.
    modport slave (
        input  src_addr, src_valid, dst_addr, dst_wr, issue_valid,
        input  jump_taken, dmem_ready, imem_ready,
        output stall, data_hazard, control_hazard, sb_valid
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: tracks in-flight register writes in a shift scoreboard.
// It raises RAW data hazards for the decode operands and generates the memory
// stall. It also holds a fixed-length decode squash after each taken jump.
module hazard_scoreboard #(
    parameter int NUM_SRC     = 2,
    parameter int REG_ADDR_W  = 5,
    parameter int WB_DEPTH    = 3,
    parameter int FLUSH_DEPTH = 2,
    parameter int BYPASS      = 0
) (
    input logic          clk,
    input logic          rst,
    hazard_scoreboard_if.slave bus
);
    // The counter is at least 2 bits wide and also wide enough to hold FLUSH_DEPTH.
    localparam int FC_W = ($clog2(FLUSH_DEPTH + 1) > 2) ? $clog2(FLUSH_DEPTH + 1) : 2;

    logic [WB_DEPTH-1:0]   v_q;
    logic [REG_ADDR_W-1:0] addr_q [WB_DEPTH];
    logic [FC_W-1:0]       fc_q;

    logic stall_c;
    logic raw_c;
    logic data_hazard_c;
    logic control_hazard_c;
    logic entry_v_in;

    // Stall from memory readiness. Forced low while reset is held.
    always_comb begin
        stall_c = ~rst & (~bus.dmem_ready | (bus.jump_taken & ~bus.imem_ready));
    end

    // Squash decode while the flush counter is running.
    always_comb begin
        control_hazard_c = ~rst & (fc_q != '0);
    end

    // RAW match of any read operand against any valid in-flight write.
    // x0 never matches. With bypass, the last entry is forwarded, so it is not a hazard.
    always_comb begin
        raw_c = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int k = 0; k < WB_DEPTH; k++) begin
                if (!((BYPASS != 0) && (k == WB_DEPTH - 1))) begin
                    if (bus.src_valid[i] &&
                        (bus.src_addr[i*REG_ADDR_W +: REG_ADDR_W] != '0) &&
                        v_q[k] &&
                        (addr_q[k] == bus.src_addr[i*REG_ADDR_W +: REG_ADDR_W])) begin
                        raw_c = 1'b1;
                    end
                end
            end
        end
    end

    // A squashed instruction cannot be stalled, so the control hazard masks the data hazard.
    always_comb begin
        data_hazard_c = bus.issue_valid & raw_c & ~control_hazard_c & ~rst;
    end

    // Only a real, non-bubbled, non-squashed write to a register other than x0 enters the scoreboard.
    always_comb begin
        entry_v_in = bus.issue_valid & bus.dst_wr & ~data_hazard_c &
                     ~control_hazard_c & (bus.dst_addr != '0);
    end

    // Shift the scoreboard one stage per non-stalled edge. The oldest entry drops off.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
            for (int k = 0; k < WB_DEPTH; k++) begin
                addr_q[k] <= '0;
            end
        end else if (!stall_c) begin
            for (int k = WB_DEPTH - 1; k > 0; k--) begin
                v_q[k]    <= v_q[k-1];
                addr_q[k] <= addr_q[k-1];
            end
            v_q[0]    <= entry_v_in;
            addr_q[0] <= bus.dst_addr;
        end
    end

    // Flush counter: loads on an accepted taken jump and counts down otherwise. It ignores jumps that are being squashed.
    always_ff @(posedge clk) begin
        if (rst) begin
            fc_q <= '0;
        end else if (!stall_c) begin
            if (bus.jump_taken && !control_hazard_c) begin
                fc_q <= FC_W'(FLUSH_DEPTH);
            end else if (fc_q != '0) begin
                fc_q <= fc_q - FC_W'(1);
            end
        end
    end

    // Drive the bus outputs.
    always_comb begin
        bus.stall          = stall_c;
        bus.data_hazard    = data_hazard_c;
        bus.control_hazard = control_hazard_c;
        bus.sb_valid       = v_q;
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard. Two instances share the same stimulus:
// dut_a has no bypass and dut_b bypasses the final stage. Expected output vectors
// are queued as each step is driven, then popped and compared mid-cycle.
module tb_hazard_scoreboard;
    localparam int NUM_SRC    = 2;
    localparam int REG_ADDR_W = 5;
    localparam int WB_DEPTH   = 3;
    localparam int W          = 11;

    logic clk;
    logic rst;

    logic [NUM_SRC*REG_ADDR_W-1:0] src_addr;
    logic [NUM_SRC-1:0]            src_valid;
    logic [REG_ADDR_W-1:0]         dst_addr;
    logic                          dst_wr;
    logic                          issue_valid;
    logic                          jump_taken;
    logic                          dmem_ready;
    logic                          imem_ready;

    logic [W-1:0] exp_q[$];
    int checks;
    int failures;

    hazard_scoreboard_if #(.NUM_SRC(NUM_SRC), .REG_ADDR_W(REG_ADDR_W), .WB_DEPTH(WB_DEPTH)) bus_a ();
    hazard_scoreboard_if #(.NUM_SRC(NUM_SRC), .REG_ADDR_W(REG_ADDR_W), .WB_DEPTH(WB_DEPTH)) bus_b ();

    assign bus_a.src_addr    = src_addr;
    assign bus_a.src_valid   = src_valid;
    assign bus_a.dst_addr    = dst_addr;
    assign bus_a.dst_wr      = dst_wr;
    assign bus_a.issue_valid = issue_valid;
    assign bus_a.jump_taken  = jump_taken;
    assign bus_a.dmem_ready  = dmem_ready;
    assign bus_a.imem_ready  = imem_ready;
    assign bus_b.src_addr    = src_addr;
    assign bus_b.src_valid   = src_valid;
    assign bus_b.dst_addr    = dst_addr;
    assign bus_b.dst_wr      = dst_wr;
    assign bus_b.issue_valid = issue_valid;
    assign bus_b.jump_taken  = jump_taken;
    assign bus_b.dmem_ready  = dmem_ready;
    assign bus_b.imem_ready  = imem_ready;

    hazard_scoreboard #(.NUM_SRC(NUM_SRC), .REG_ADDR_W(REG_ADDR_W), .WB_DEPTH(WB_DEPTH),
                        .FLUSH_DEPTH(2), .BYPASS(0)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    hazard_scoreboard #(.NUM_SRC(NUM_SRC), .REG_ADDR_W(REG_ADDR_W), .WB_DEPTH(WB_DEPTH),
                        .FLUSH_DEPTH(2), .BYPASS(1)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    // Clock and reset.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pack one expected vector: {stall, dh_a, dh_b, ch_a, ch_b, sb_a, sb_b}.
    function automatic logic [W-1:0] ex(input logic st, input logic dha, input logic dhb,
                                        input logic cha, input logic chb,
                                        input logic [2:0] sva, input logic [2:0] svb);
        return {st, dha, dhb, cha, chb, sva, svb};
    endfunction

    // Driver task: all inputs go to the idle state with no instruction and memories ready.
    task automatic idle();
        rst         = 1'b0;
        src_addr    = '0;
        src_valid   = '0;
        dst_addr    = '0;
        dst_wr      = 1'b0;
        issue_valid = 1'b0;
        jump_taken  = 1'b0;
        dmem_ready  = 1'b1;
        imem_ready  = 1'b1;
    endtask

    // Queue the expected value for the current cycle, check it mid-cycle, then advance one clock.
    task automatic cyc(input string tag, input logic [W-1:0] e);
        logic [W-1:0] obs;
        logic [W-1:0] want;
        exp_q.push_back(e);
        @(negedge clk);
        obs = {bus_a.stall, bus_a.data_hazard, bus_b.data_hazard,
               bus_a.control_hazard, bus_b.control_hazard, bus_a.sb_valid, bus_b.sb_valid};
        want = exp_q.pop_front();
        checks++;
        assert (obs === want) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, want);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        idle();
        // Reset asserted while stall and jump sources are active.
        rst         = 1'b1;
        dmem_ready  = 1'b0;
        jump_taken  = 1'b1;
        issue_valid = 1'b1;
        dst_wr      = 1'b1;
        dst_addr    = 5'd3;
        src_addr    = {5'd0, 5'd3};
        src_valid   = 2'b01;
        @(posedge clk);
        #1;
        cyc("reset_c0", ex(0, 0, 0, 0, 0, 3'b000, 3'b000));
        cyc("reset_c1", ex(0, 0, 0, 0, 0, 3'b000, 3'b000));
        idle();
        cyc("post_reset_idle", ex(0, 0, 0, 0, 0, 3'b000, 3'b000));

        // RAW: the producer writes x5, then consumers read x5 on port 0.
        issue_valid = 1'b1; dst_wr = 1'b1; dst_addr = 5'd5;
        cyc("raw_c0", ex(0, 0, 0, 0, 0, 3'b000, 3'b000));
        dst_wr = 1'b0; dst_addr = 5'd0; src_addr = {5'd0, 5'd5}; src_valid = 2'b01;
        cyc("raw_c1", ex(0, 1, 1, 0, 0, 3'b001, 3'b001));
        cyc("raw_c2", ex(0, 1, 1, 0, 0, 3'b010, 3'b010));
        cyc("raw_c3", ex(0, 1, 0, 0, 0, 3'b100, 3'b100));
        cyc("raw_c4", ex(0, 0, 0, 0, 0, 3'b000, 3'b000));
        idle();

        // A write to x0 is never tracked and a read of x0 never matches.
        issue_valid = 1'b1; dst_wr = 1'b1; dst_addr = 5'd0;
        cyc("x0_wr", ex(0, 0, 0, 0, 0, 3'b000, 3'b000));
        dst_wr = 1'b0; src_addr = {5'd0, 5'd0}; src_valid = 2'b01;
        cyc("x0_rd", ex(0, 0, 0, 0, 0, 3'b000, 3'b000));
        // Port 1 matching and the src_valid qualification.
        dst_wr = 1'b1; dst_addr = 5'd7; src_valid = 2'b00;
        cyc("p1_wr", ex(0, 0, 0, 0, 0, 3'b000, 3'b000));
        dst_wr = 1'b0; dst_addr = 5'd0; src_addr = {5'd7, 5'd0}; src_valid = 2'b10;
        cyc("p1_rd_valid", ex(0, 1, 1, 0, 0, 3'b001, 3'b001));
        src_valid = 2'b00;
        cyc("p1_rd_invalid", ex(0, 0, 0, 0, 0, 3'b010, 3'b010));
        idle();
        cyc("p1_drain0", ex(0, 0, 0, 0, 0, 3'b100, 3'b100));
        cyc("p1_drain1", ex(0, 0, 0, 0, 0, 3'b000, 3'b000));

        // Memory stall freezes the scoreboard.
        issue_valid = 1'b1; dst_wr = 1'b1; dst_addr = 5'd9;
        cyc("mem_issue", ex(0, 0, 0, 0, 0, 3'b000, 3'b000));
        idle();
        dmem_ready = 1'b0;
        for (int n = 0; n < 4; n++) begin
            cyc("mem_stall", ex(1, 0, 0, 0, 0, 3'b001, 3'b001));
        end
        dmem_ready = 1'b1;
        cyc("mem_release", ex(0, 0, 0, 0, 0, 3'b001, 3'b001));
        cyc("mem_adv", ex(0, 0, 0, 0, 0, 3'b010, 3'b010));
        cyc("mem_drain0", ex(0, 0, 0, 0, 0, 3'b100, 3'b100));
        cyc("mem_drain1", ex(0, 0, 0, 0, 0, 3'b000, 3'b000));

        // Control hazard masks a pending RAW, and a second jump during the squash is ignored.
        issue_valid = 1'b1; dst_wr = 1'b1; dst_addr = 5'd4; jump_taken = 1'b1;
        cyc("ctl_c0", ex(0, 0, 0, 0, 0, 3'b000, 3'b000));
        dst_wr = 1'b0; dst_addr = 5'd0; src_addr = {5'd0, 5'd4}; src_valid = 2'b01;
        cyc("ctl_c1", ex(0, 0, 0, 1, 1, 3'b001, 3'b001));
        jump_taken = 1'b0;
        cyc("ctl_c2", ex(0, 0, 0, 1, 1, 3'b010, 3'b010));
        cyc("ctl_c3", ex(0, 1, 0, 0, 0, 3'b100, 3'b100));
        cyc("ctl_c4", ex(0, 0, 0, 0, 0, 3'b000, 3'b000));
        idle();

        // A jump while imem is not ready stalls, and the counter loads only when imem becomes ready.
        jump_taken = 1'b1; imem_ready = 1'b0;
        for (int n = 0; n < 3; n++) begin
            cyc("jmp_imem_stall", ex(1, 0, 0, 0, 0, 3'b000, 3'b000));
        end
        imem_ready = 1'b1;
        cyc("jmp_imem_go", ex(0, 0, 0, 0, 0, 3'b000, 3'b000));
        jump_taken = 1'b0;
        cyc("jmp_flush1", ex(0, 0, 0, 1, 1, 3'b000, 3'b000));
        cyc("jmp_flush2", ex(0, 0, 0, 1, 1, 3'b000, 3'b000));
        cyc("jmp_done", ex(0, 0, 0, 0, 0, 3'b000, 3'b000));

        // Reset mid-operation clears the scoreboard even while dmem is not ready.
        issue_valid = 1'b1; dst_wr = 1'b1; dst_addr = 5'd6;
        cyc("rst_mid_issue", ex(0, 0, 0, 0, 0, 3'b000, 3'b000));
        idle();
        rst = 1'b1; dmem_ready = 1'b0;
        cyc("rst_mid_hold", ex(0, 0, 0, 0, 0, 3'b001, 3'b001));
        idle();
        cyc("rst_mid_clear", ex(0, 0, 0, 0, 0, 3'b000, 3'b000));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
